// File: rtl/mem_loader.sv
// Byte-stream memory loader: parses a big-endian {count, address, data words} stream and issues word writes.
// Optional checksum phase is compiled in with MEM_LOADER_CHECKSUM_EN.
module mem_loader (
  input  logic        c_CLOCK,
  input  logic        i_RESET,
  input  logic        i_START,
  input  logic [7:0]  i_BYTE,
  input  logic        f_BYTEVALID,
  output logic        o_BYTEREADY,
  output logic [15:0] o_WADDR,
  output logic [15:0] o_WDATA,
  output logic        f_WRITE,
  output logic        o_CPUHOLD,
  output logic        o_DONE,
  output logic        o_ERROR
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    ADDR_HI = 4'd3,
    ADDR_LO = 4'd4,
    DATA_HI = 4'd5,
    DATA_LO = 4'd6,
    WRITE   = 4'd7,
`ifdef MEM_LOADER_CHECKSUM_EN
    CSUM_HI = 4'd8,
    CSUM_LO = 4'd9,
`endif
    DONE    = 4'd10
  } state_t;

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CSUM_HI;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t      state_r;
  state_t      state_s;
  logic [15:0] count_r;
  logic [15:0] count_s;
  logic [15:0] addr_r;
  logic [15:0] addr_s;
  logic [7:0]  hi_byte_r;
  logic [7:0]  hi_byte_s;
  logic [15:0] waddr_r;
  logic [15:0] waddr_s;
  logic [15:0] wdata_r;
  logic [15:0] wdata_s;
  logic        write_r;
  logic        write_s;
  logic        ready_r;
  logic        ready_s;
  logic        hold_r;
  logic        hold_s;
  logic        done_r;
  logic        done_s;
  logic        accept_s;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [15:0] sum_r;
  logic [15:0] sum_s;
  logic [7:0]  csum_hi_r;
  logic [7:0]  csum_hi_s;
  logic        error_r;
  logic        error_s;

  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
    sum16 = a + b;
  endfunction
`endif

  function automatic logic byte_state(input state_t s);
    case (s)
      LEN_HI, LEN_LO, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: byte_state = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
      CSUM_HI, CSUM_LO:                                   byte_state = 1'b1;
`endif
      default:                                            byte_state = 1'b0;
    endcase
  endfunction

  // ready_r mirrors the current state, so a byte is taken exactly when the handshake completes
  assign accept_s = f_BYTEVALID & ready_r;

  // Next-state and datapath next values; outputs are decoded from the next state and registered
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    addr_s    = addr_r;
    hi_byte_s = hi_byte_r;
    waddr_s   = waddr_r;
    wdata_s   = wdata_r;
`ifdef MEM_LOADER_CHECKSUM_EN
    sum_s     = sum_r;
    csum_hi_s = csum_hi_r;
    error_s   = error_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (i_START) begin
          state_s = LEN_HI;
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_s   = 16'h0000;
          error_s = 1'b0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      LEN_HI: begin
        if (accept_s) begin
          count_s = {i_BYTE, count_r[7:0]};
          state_s = LEN_LO;
        end else begin
          state_s = state_r;
        end
      end
      LEN_LO: begin
        if (accept_s) begin
          count_s = {count_r[15:8], i_BYTE};
          state_s = ADDR_HI;
        end else begin
          state_s = state_r;
        end
      end
      ADDR_HI: begin
        if (accept_s) begin
          addr_s  = {i_BYTE, addr_r[7:0]};
          state_s = ADDR_LO;
        end else begin
          state_s = state_r;
        end
      end
      ADDR_LO: begin
        if (accept_s) begin
          addr_s  = {addr_r[15:8], i_BYTE};
          state_s = (count_r != 16'h0000) ? DATA_HI : END_STATE;
        end else begin
          state_s = state_r;
        end
      end
      DATA_HI: begin
        if (accept_s) begin
          hi_byte_s = i_BYTE;
          state_s   = DATA_LO;
        end else begin
          state_s = state_r;
        end
      end
      DATA_LO: begin
        // Output registers load here so they present the word throughout WRITE and hold afterwards
        if (accept_s) begin
          waddr_s = addr_r;
          wdata_s = {hi_byte_r, i_BYTE};
          state_s = WRITE;
        end else begin
          state_s = state_r;
        end
      end
      WRITE: begin
        addr_s  = addr_r + 16'd1;
        count_s = count_r - 16'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_s   = sum16(sum_r, wdata_r);
`endif
        state_s = (count_r != 16'd1) ? DATA_HI : END_STATE;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      CSUM_HI: begin
        if (accept_s) begin
          csum_hi_s = i_BYTE;
          state_s   = CSUM_LO;
        end else begin
          state_s = state_r;
        end
      end
      CSUM_LO: begin
        if (accept_s) begin
          error_s = ({csum_hi_r, i_BYTE} != sum_r);
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
    write_s = (state_s == WRITE);
    ready_s = byte_state(state_s);
    hold_s  = (state_s != IDLE) && (state_s != DONE);
    done_s  = (state_s == DONE);
  end

  // State, datapath and registered output flops with synchronous reset
  always_ff @(posedge c_CLOCK) begin
    if (i_RESET) begin
      state_r   <= IDLE;
      count_r   <= 16'h0000;
      addr_r    <= 16'h0000;
      hi_byte_r <= 8'h00;
      waddr_r   <= 16'h0000;
      wdata_r   <= 16'h0000;
      write_r   <= 1'b0;
      ready_r   <= 1'b0;
      hold_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_r     <= 16'h0000;
      csum_hi_r <= 8'h00;
      error_r   <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      addr_r    <= addr_s;
      hi_byte_r <= hi_byte_s;
      waddr_r   <= waddr_s;
      wdata_r   <= wdata_s;
      write_r   <= write_s;
      ready_r   <= ready_s;
      hold_r    <= hold_s;
      done_r    <= done_s;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_r     <= sum_s;
      csum_hi_r <= csum_hi_s;
      error_r   <= error_s;
`endif
    end
  end

  assign o_BYTEREADY = ready_r;
  assign o_WADDR     = waddr_r;
  assign o_WDATA     = wdata_r;
  assign f_WRITE     = write_r;
  assign o_CPUHOLD   = hold_r;
  assign o_DONE      = done_r;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign o_ERROR     = error_r;
`else
  assign o_ERROR     = 1'b0;
`endif

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have port c_CLOCK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_RESET, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port i_START, input, 1 bit: begin a load session; sampled only in IDLE and DONE.
REQ-004 SHALL have port i_BYTE, input, 8 bits: incoming stream byte.
REQ-005 SHALL have port f_BYTEVALID, input, 1 bit: i_BYTE is valid.
REQ-006 SHALL have port o_BYTEREADY, output, 1 bit: the loader accepts i_BYTE this cycle.
REQ-007 SHALL have port o_WADDR, output, 16 bits: memory write address, driving the Memory i_WADDR input.
REQ-008 SHALL have port o_WDATA, output, 16 bits: memory write data, driving the Memory i_DATA input.
REQ-009 SHALL have port f_WRITE, output, 1 bit: one-cycle memory write strobe.
REQ-010 SHALL have port o_CPUHOLD, output, 1 bit: holds the CPU stalled while a load is in progress.
REQ-011 SHALL have port o_DONE, output, 1 bit: the load completed.
REQ-012 SHALL have port o_ERROR, output, 1 bit: checksum mismatch; constant 0 when the checksum feature is compiled out.

Function
REQ-013 SHALL use states IDLE, LEN_HI, LEN_LO, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WRITE, CSUM_HI, CSUM_LO, DONE.
REQ-014 SHALL accept a byte only when f_BYTEVALID and o_BYTEREADY are both 1 at the same clock edge; o_BYTEREADY SHALL be 1 only in the LEN_*, ADDR_*, DATA_* and CSUM_* states.
REQ-015 SHALL treat the stream as big-endian fields: word count N (16 bits), then start address A (16 bits), then N data words, each sent high byte first.
REQ-016 SHALL advance from IDLE or DONE to LEN_HI one cycle after i_START=1, clearing o_DONE and o_ERROR on that transition.
REQ-017 SHALL step LEN_HI->LEN_LO->ADDR_HI->ADDR_LO, advancing one state per accepted byte.
REQ-018 SHALL, after ADDR_LO, go to DATA_HI if N!=0; otherwise it SHALL go to the end state (CSUM_HI if the feature is compiled in, DONE if not).
REQ-019 SHALL assemble a data word across DATA_HI and DATA_LO, then enter WRITE.
REQ-020 SHALL, in WRITE, assert f_WRITE for exactly one cycle with o_WADDR = current address and o_WDATA = the assembled word.
REQ-021 SHALL, after the WRITE cycle, increment the address modulo 2^16 (0xFFFF wraps to 0x0000) and decrement the remaining count.
REQ-022 SHALL, after the WRITE cycle, go to DATA_HI if the remaining count is nonzero, else go to the end state.
REQ-023 SHALL keep f_WRITE at 0 in every state except WRITE.
REQ-024 SHALL hold o_WADDR and o_WDATA stable outside WRITE, at their last values.
REQ-025 SHALL drive o_CPUHOLD = 1 in every state except IDLE and DONE.
REQ-026 SHALL drive o_DONE = 1 only in DONE.
REQ-027 SHALL ignore i_START while a session is in progress.
REQ-028 SHALL keep its state unchanged in any byte-accepting state while f_BYTEVALID=0, with no timeout.

Reset
REQ-029 SHALL, when i_RESET=1 at a clock edge, enter IDLE and clear all of: count, address, o_WADDR, o_WDATA, f_WRITE, o_DONE, o_ERROR; at reset o_CPUHOLD=0 and o_BYTEREADY=0.
REQ-030 SHALL give reset priority over i_START and over a pending byte; a reset during a session SHALL abort it, with no further writes issued.

Configuration
REQ-031 SHALL include the checksum phase only when MEM_LOADER_CHECKSUM_EN is defined.
REQ-032 SHALL, with MEM_LOADER_CHECKSUM_EN defined, accumulate the sum modulo 2^16 of all written data words (the sum is 0 when N=0).
REQ-033 SHALL, with MEM_LOADER_CHECKSUM_EN defined, receive a 16-bit checksum in CSUM_HI/CSUM_LO, then enter DONE with o_ERROR=1 if the checksum differs from the sum.
REQ-034 SHALL, without MEM_LOADER_CHECKSUM_EN, omit the CSUM states and hold o_ERROR at 0.

Verification
REQ-035 SHALL cover: stream 00 02 01 00 AB CD 12 34 -> writes 0xABCD@0x0100, then 0x1234@0x0101; o_DONE=1; o_CPUHOLD drops in DONE.
REQ-036 SHALL cover: N=0, A=0x0040 -> no f_WRITE pulse; reaches DONE (checksum 00 00 if enabled, with o_ERROR=0).
REQ-037 SHALL cover: N=2, A=0xFFFF -> writes to 0xFFFF, then 0x0000.
REQ-038 SHALL cover: f_BYTEVALID toggled randomly plus i_START pulsed mid-session -> identical writes; the mid-session i_START has no effect.
REQ-039 SHALL cover: i_RESET asserted after the first DATA_HI byte -> IDLE next cycle, no write, o_CPUHOLD=0.
REQ-040 SHALL cover, with MEM_LOADER_CHECKSUM_EN defined: words 0x0001 and 0xFFFF sent with checksum 0x0000 -> o_ERROR=0; the same words with checksum 0x0001 -> o_ERROR=1.
